muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Multi-cycle integer multiply/divide unit that owns the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO. Decode issues operands (already forwarded rs/rt data) with a start pulse. The block sequences a radix-2 shift-add / restoring-divide datapath through a small FSM. It raises stall back to decode whenever a request cannot be accepted in the current cycle. It sits beside the ALU in EX and is the only writer of HI/LO.

Parameters:
DBZ_LO, 32'hFFFF_FFFF, LO value produced by any divide with op_y == 0

Ports:
clk  input  1  pipeline clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  decode requests a mul/div operation this cycle
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
op_x  input  32  rs data (multiplicand / dividend)
op_y  input  32  rt data (multiplier / divisor)
flush  input  1  pipeline flush; aborts an in-flight operation
hilo_we  input  1  MTHI/MTLO write request
hilo_sel  input  1  0 selects LO, 1 selects HI for hilo_we
hilo_wdata  input  32  data for MTHI/MTLO
hilo_re  input  1  MFHI/MFLO in decode needs hi/lo this cycle
hi  output  32  architectural HI register
lo  output  32  architectural LO register
busy  output  1  FSM not in IDLE or DONE
done  output  1  one-cycle pulse; hi/lo hold the new result
stall  output  1  combinational; decode must hold its instruction

Behaviour:
- Reset (rst_n low, async): state=IDLE, hi=0, lo=0, count=0, busy=0, done=0. stall=0 while start/hilo_we/hilo_re are low.
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE/DONE with start=1: latch op, op_x, op_y; go to PREP. Start is accepted only in IDLE or DONE.
- PREP (1 cycle): for signed ops, record sign_x, sign_y and take absolute values; clear accumulator; count=0. Go to RUN.
- RUN (exactly 32 cycles, count 0..31): one radix-2 step per cycle.
  - MUL: 64-bit {acc, multiplier} shift-add.
  - DIV: restoring subtract-shift, 33-bit partial remainder.
  - count==31 -> FIX.
- FIX (1 cycle), then DONE:
  - MULT: negate the 64-bit product if sign_x^sign_y; HI=product[63:32], LO=product[31:0].
  - DIV: negate the quotient if sign_x^sign_y; the remainder takes the sign of the dividend. LO=quotient, HI=remainder.
  - Unsigned ops: no correction.
  - hi/lo are written on the FIX->DONE edge.
- Latency: start high in cycle 0 -> done high in cycle 35 (PREP 1, RUN 32, FIX 1, DONE 1). done is high only in DONE.
- DONE -> IDLE next cycle, unless start is accepted (-> PREP).
- Divide by zero (op_y==0, DIV or DIVU): LO=DBZ_LO, HI=op_x as latched (unmodified). Latency unchanged.
- Signed overflow (0x8000_0000 / 0xFFFF_FFFF): LO=0x8000_0000, HI=0.
- busy = state in {PREP, RUN, FIX}.
- stall = busy & (start | hilo_we | hilo_re). hi/lo are readable and writable in IDLE and DONE.
- hilo_we in IDLE/DONE writes the selected register on the next edge. If start is also high in the same cycle, start has priority and hilo_we is dropped; decode never issues both.
- flush (any state): next state IDLE, done=0, hi/lo unchanged, in-flight result discarded.
- flush and start in the same cycle: flush wins and start is not accepted.
- Reset asserted mid-operation: immediate return to the reset values above.
- op_x/op_y/op are ignored after the start-accept edge; changing them during RUN has no effect.

Test Plan:
- MULTU 0xFFFF_FFFF x 0xFFFF_FFFF, start at cycle 0 -> done at cycle 35, HI=0xFFFF_FFFE, LO=0x0000_0001; busy high in cycles 1-34.
- MULT -7 x 3 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFEB. DIV -7 / 2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
- DIVU 100 / 0 -> LO=0xFFFF_FFFF, HI=100. DIV 0x8000_0000 / 0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
- hilo_re held high from cycle 2 -> stall=1 through cycle 34, stall=0 in cycle 35 with new HI/LO visible; second start in cycle 10 -> stalled and not accepted.
- MTLO 0x1234 in IDLE, then DIVU 9/2 with flush at cycle 20 -> state IDLE at cycle 21, LO stays 0x1234, done never pulses.
- rst_n low at cycle 15 of a MULTU -> hi=lo=0, busy=0 asynchronously. Back-to-back start accepted in the DONE cycle -> second done exactly 35 cycles later.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer_if
// Bundle between decode (master) and the multiply/divide unit (slave).
//
// Handshake: start is the request-valid; the request is taken on the rising
// edge where start=1, flush=0 and the unit is not busy. While busy, stall=1
// tells decode to hold start/hilo_we/hilo_re and their data until stall drops.
// hilo_we (MTHI/MTLO) is taken on the edge where it is high, start is low,
// flush is low and the unit is not busy. hilo_re (MFHI/MFLO) may read hi/lo in
// any cycle where stall=0.
//
// Signals:
//   start, op[1:0], op_x, op_y   : operation request and forwarded operands
//   flush                        : abort any in-flight operation
//   hilo_we, hilo_sel, hilo_wdata: MTHI (sel=1) / MTLO (sel=0) write
//   hilo_re                      : MFHI/MFLO read request
//   hi, lo                       : architectural HI/LO registers
//   busy, done, stall            : unit status
// -----------------------------------------------------------------------------
interface muldiv_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] op_x;
  logic [31:0] op_y;
  logic        flush;
  logic        hilo_we;
  logic        hilo_sel;
  logic [31:0] hilo_wdata;
  logic        hilo_re;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  modport master (
    output start, op, op_x, op_y, flush, hilo_we, hilo_sel, hilo_wdata, hilo_re,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, op_x, op_y, flush, hilo_we, hilo_sel, hilo_wdata, hilo_re,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Sequence: IDLE/DONE -start-> PREP (1) -> RUN (32) -> FIX (1) -> DONE (1).
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bus        : muldiv_sequencer_if.slave (request, HI/LO access, status)
//   dbg_state  : current FSM state (0 IDLE, 1 PREP, 2 RUN, 3 FIX, 4 DONE)
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter logic [31:0] DBZ_LO = 32'hFFFF_FFFF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  muldiv_sequencer_if.slave          bus,
  output logic [2:0]                 dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  op_q;
  logic [31:0] x_q, y_q;
  logic        sign_x, sign_y;
  logic [32:0] acc;     // multiply: upper product half; divide: partial remainder
  logic [31:0] mq;      // multiply: multiplier/low product; divide: dividend/quotient
  logic [31:0] ymag;    // |multiplier operand| or |divisor|
  logic [4:0]  count;
  logic [31:0] hi_q, lo_q;

  logic open_st;
  logic accept;
  logic is_div, is_signed;

  assign open_st   = (state == IDLE) || (state == DONE);
  // flush beats start in the same cycle
  assign accept    = bus.start & ~bus.flush & open_st;
  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nx = state;
    if (bus.flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nx = PREP;
        PREP:    state_nx = RUN;
        RUN:     if (count == 5'd31) state_nx = FIX;
        FIX:     state_nx = DONE;
        DONE:    state_nx = accept ? PREP : IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.busy  = (state == PREP) || (state == RUN) || (state == FIX);
    bus.done  = (state == DONE);
    bus.stall = bus.busy & (bus.start | bus.hilo_we | bus.hilo_re);
  end

  assign dbg_state = state;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

  // ---------------- datapath step logic ----------------
  logic [31:0] x_abs, y_abs;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [32:0] acc_step;
  logic [31:0] mq_step;
  logic [63:0] prod, prod_fix;
  logic [31:0] q_fix, r_fix;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    x_abs = (is_signed && x_q[31]) ? -x_q : x_q;
    y_abs = (is_signed && y_q[31]) ? -y_q : y_q;

    mul_sum   = mq[0] ? (acc + {1'b0, ymag}) : acc;
    div_shift = {acc[31:0], mq[31]};
    div_diff  = div_shift - {1'b0, ymag};

    if (is_div) begin
      // restoring step: keep the difference only when it did not go negative
      if (!div_diff[32]) begin
        acc_step = div_diff;
        mq_step  = {mq[30:0], 1'b1};
      end else begin
        acc_step = div_shift;
        mq_step  = {mq[30:0], 1'b0};
      end
    end else begin
      acc_step = {1'b0, mul_sum[32:1]};
      mq_step  = {mul_sum[0], mq[31:1]};
    end

    prod     = {acc[31:0], mq};
    prod_fix = (sign_x ^ sign_y) ? -prod : prod;
    q_fix    = (sign_x ^ sign_y) ? -mq : mq;
    r_fix    = sign_x ? -acc[31:0] : acc[31:0];

    if (!is_div) begin
      res_hi = prod_fix[63:32];
      res_lo = prod_fix[31:0];
    end else if (y_q == 32'd0) begin
      res_hi = x_q;
      res_lo = DBZ_LO;
    end else begin
      res_hi = r_fix;
      res_lo = q_fix;
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= 2'd0;
      x_q    <= 32'd0;
      y_q    <= 32'd0;
      sign_x <= 1'b0;
      sign_y <= 1'b0;
      acc    <= 33'd0;
      mq     <= 32'd0;
      ymag   <= 32'd0;
      count  <= 5'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      if (accept) begin
        op_q <= bus.op;
        x_q  <= bus.op_x;
        y_q  <= bus.op_y;
      end else if (open_st && bus.hilo_we && !bus.start && !bus.flush) begin
        if (bus.hilo_sel) hi_q <= bus.hilo_wdata;
        else              lo_q <= bus.hilo_wdata;
      end

      case (state)
        PREP: begin
          sign_x <= is_signed & x_q[31];
          sign_y <= is_signed & y_q[31];
          mq     <= x_abs;
          ymag   <= y_abs;
          acc    <= 33'd0;
          count  <= 5'd0;
        end
        RUN: begin
          acc   <= acc_step;
          mq    <= mq_step;
          count <= count + 5'd1;
        end
        FIX: begin
          if (!bus.flush) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Directed and randomized checks of muldiv_sequencer against an arithmetic
// reference model. Inputs change 1 time unit after the rising edge; outputs
// are sampled on the falling edge. "Cycle N" counts rising edges after the
// cycle in which start was driven.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

  localparam logic [31:0] DBZ = 32'hFFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic [2:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  muldiv_sequencer_if bus();

  muldiv_sequencer #(.DBZ_LO(DBZ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int vectors     = 0;
  int miscompares = 0;

  // expected result queue: {hi, lo} per issued operation
  logic [63:0] exp_q[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic, returns {hi, lo}.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    longint sx, sy, q, m, p;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = 64'd0;
    case (o)
      2'b00: begin p = sx * sy; r = p; end
      2'b01: r = {32'd0, x} * {32'd0, y};
      2'b10: begin
        if (y == 32'd0) r = {x, DBZ};
        else begin
          q = sx / sy;
          m = sx % sy;
          r = {m[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'd0) r = {x, DBZ};
        else            r = {x % y, x / y};
      end
    endcase
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.start      = 1'b0;
    bus.op         = 2'd0;
    bus.op_x       = 32'd0;
    bus.op_y       = 32'd0;
    bus.flush      = 1'b0;
    bus.hilo_we    = 1'b0;
    bus.hilo_sel   = 1'b0;
    bus.hilo_wdata = 32'd0;
    bus.hilo_re    = 1'b0;
  endtask

  // Issues one operation starting now (posedge+1) and checks it through
  // cycle 36; returns at posedge+1 of cycle 37.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit scramble);
    logic [63:0] exp;
    exp_q.push_back(ref_model(o, x, y));
    bus.start = 1'b1;
    bus.op    = o;
    bus.op_x  = x;
    bus.op_y  = y;
    mid();
    check({tag, " stall_at_start"}, {63'd0, bus.stall}, 64'd0);
    next_cycle();
    bus.start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      if (scramble) begin
        bus.op_x = $urandom;
        bus.op_y = $urandom;
        bus.op   = 2'($urandom_range(0, 3));
      end
      mid();
      if (c == 1 || c == 34) check({tag, " busy"}, {63'd0, bus.busy}, 64'd1);
      if (c == 34) check({tag, " done_early"}, {63'd0, bus.done}, 64'd0);
      next_cycle();
    end
    mid();
    exp = exp_q.pop_front();
    check({tag, " done"}, {63'd0, bus.done}, 64'd1);
    check({tag, " busy_done"}, {63'd0, bus.busy}, 64'd0);
    check({tag, " hilo"}, {bus.hi, bus.lo}, exp);
    next_cycle();
    mid();
    check({tag, " done_pulse"}, {63'd0, bus.done}, 64'd0);
    next_cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] exp;
    logic [31:0] rx, ry;
    logic [1:0]  ro;
    int          done_seen;

    drive_idle();
    rst_n = 1'b0;
    repeat (3) next_cycle();
    mid();
    check("reset hi", {32'd0, bus.hi}, 64'd0);
    check("reset lo", {32'd0, bus.lo}, 64'd0);
    check("reset busy", {63'd0, bus.busy}, 64'd0);
    check("reset done", {63'd0, bus.done}, 64'd0);
    check("reset stall", {63'd0, bus.stall}, 64'd0);
    check("reset state", {61'd0, dbg_state}, 64'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // directed operations with hand-derived expectations
    exp_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
    check("model multu", ref_model(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), exp_q.pop_front());
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check("multu_max hi", {32'd0, bus.hi}, 64'hFFFF_FFFE);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFF9, 32'd3, 1'b0);
    check("mult_neg lo", {32'd0, bus.lo}, 64'hFFFF_FFEB);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg lo", {32'd0, bus.lo}, 64'hFFFF_FFFD);
    check("div_neg hi", {32'd0, bus.hi}, 64'hFFFF_FFFF);
    run_op("divu_dbz", 2'b11, 32'd100, 32'd0, 1'b1);
    check("divu_dbz hi", {32'd0, bus.hi}, 64'd100);
    check("divu_dbz lo", {32'd0, bus.lo}, 64'hFFFF_FFFF);
    run_op("div_dbz", 2'b10, 32'hFFFF_FF00, 32'd0, 1'b0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf lo", {32'd0, bus.lo}, 64'h8000_0000);
    check("div_ovf hi", {32'd0, bus.hi}, 64'd0);

    // randomized operations, operands scrambled during RUN
    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = ($urandom_range(0, 5) == 0) ? 32'd0 :
           ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 3) == 0) rx = 32'($urandom_range(0, 1000));
      run_op("random", ro, rx, ry, 1'b1);
    end

    // stall: hilo_re held from cycle 2; a second start in cycle 10 is refused
    exp = ref_model(2'b11, 32'd1000, 32'd7);
    bus.start = 1'b1; bus.op = 2'b11; bus.op_x = 32'd1000; bus.op_y = 32'd7;
    next_cycle();
    bus.start = 1'b0;
    next_cycle();
    bus.hilo_re = 1'b1;
    for (int c = 2; c <= 34; c++) begin
      if (c == 10) begin
        bus.start = 1'b1; bus.op = 2'b01; bus.op_x = 32'd5; bus.op_y = 32'd9;
      end else begin
        bus.start = 1'b0;
      end
      mid();
      check("stall busy", {63'd0, bus.stall}, 64'd1);
      next_cycle();
    end
    mid();
    check("stall released", {63'd0, bus.stall}, 64'd0);
    check("stall done", {63'd0, bus.done}, 64'd1);
    check("stall hilo", {bus.hi, bus.lo}, exp);
    next_cycle();
    bus.hilo_re = 1'b0;
    mid();
    check("second start refused", {63'd0, bus.busy}, 64'd0);
    next_cycle();

    // MTLO / MTHI in IDLE, then a flushed DIVU
    bus.hilo_we = 1'b1; bus.hilo_sel = 1'b0; bus.hilo_wdata = 32'h1234;
    next_cycle();
    bus.hilo_sel = 1'b1; bus.hilo_wdata = 32'hABCD;
    mid();
    check("mtlo", {32'd0, bus.lo}, 64'h1234);
    next_cycle();
    bus.hilo_we = 1'b0;
    mid();
    check("mthi", {32'd0, bus.hi}, 64'hABCD);
    next_cycle();
    bus.start = 1'b1; bus.op = 2'b11; bus.op_x = 32'd9; bus.op_y = 32'd2;
    next_cycle();
    bus.start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      bus.flush = (c == 20);
      next_cycle();
    end
    bus.flush = 1'b0;
    mid();
    check("flush state", {61'd0, dbg_state}, 64'd0);
    check("flush busy", {63'd0, bus.busy}, 64'd0);
    check("flush lo", {32'd0, bus.lo}, 64'h1234);
    done_seen = 0;
    for (int c = 21; c <= 40; c++) begin
      next_cycle();
      mid();
      if (bus.done) done_seen++;
    end
    check("flush no done", 64'(done_seen), 64'd0);
    check("flush hi", {32'd0, bus.hi}, 64'hABCD);
    next_cycle();

    // asynchronous reset in the middle of a MULTU
    bus.start = 1'b1; bus.op = 2'b01; bus.op_x = 32'hFFFF_FFFF; bus.op_y = 32'd3;
    next_cycle();
    bus.start = 1'b0;
    repeat (14) next_cycle();
    rst_n = 1'b0;
    #1;
    check("async rst hi", {32'd0, bus.hi}, 64'd0);
    check("async rst lo", {32'd0, bus.lo}, 64'd0);
    check("async rst busy", {63'd0, bus.busy}, 64'd0);
    check("async rst state", {61'd0, dbg_state}, 64'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // back-to-back: second start accepted in the DONE cycle
    exp = ref_model(2'b00, 32'hFFFF_FFF9, 32'd3);
    bus.start = 1'b1; bus.op = 2'b00; bus.op_x = 32'hFFFF_FFF9; bus.op_y = 32'd3;
    next_cycle();
    bus.start = 1'b0;
    repeat (34) next_cycle();
    bus.start = 1'b1; bus.op = 2'b11; bus.op_x = 32'd100; bus.op_y = 32'd7;
    mid();
    check("b2b first done", {63'd0, bus.done}, 64'd1);
    check("b2b first hilo", {bus.hi, bus.lo}, exp);
    check("b2b accept stall", {63'd0, bus.stall}, 64'd0);
    next_cycle();
    bus.start = 1'b0;
    mid();
    check("b2b busy", {63'd0, bus.busy}, 64'd1);
    repeat (33) next_cycle();
    mid();
    check("b2b not early", {63'd0, bus.done}, 64'd0);
    next_cycle();
    mid();
    check("b2b second done", {63'd0, bus.done}, 64'd1);
    check("b2b second hilo", {bus.hi, bus.lo}, {32'd2, 32'd14});
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
